// File: rtl/ocp_slave_mem_pkg.sv
// Shared OCP bus types and helpers for the local-memory responder.
package ocp_slave_mem_pkg;

    localparam int unsigned OCP_ADDR_W = 32;
    localparam int unsigned OCP_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RDEX = 3'd3,
        RDL  = 3'd4,
        WRNP = 3'd5,
        WRC  = 3'd6,
        BCST = 3'd7
    } Ocp_cmd;

    typedef enum logic [1:0] {
        NULL = 2'd0,
        DVA  = 2'd1,
        FAIL = 2'd2,
        ERR  = 2'd3
    } Ocp_resp;

    typedef struct packed {
        Ocp_cmd                  cmd;
        logic [OCP_ADDR_W-1:0]   addr;
        logic [OCP_DATA_W-1:0]   data;
        logic [OCP_DATA_W/8-1:0] byteen;
    } Ocp_req;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic logic is_write(input Ocp_cmd c);
        return (c == WR) || (c == WRNP) || (c == WRC) || (c == BCST);
    endfunction

    function automatic logic is_read(input Ocp_cmd c);
        return (c == RD) || (c == RDEX) || (c == RDL);
    endfunction

    function automatic logic needs_resp(input Ocp_cmd c);
        return !((c == IDLE) || (c == WR) || (c == BCST));
    endfunction

endpackage

// File: rtl/ocp_slave_mem_array.sv
// Byte-enabled single-port memory with registered read; contents are not reset.
module ocp_slave_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned IDX_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
                    if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ocp_slave_mem.sv
// OCP slave terminating the bus in local word memory with a one-entry response slot.
// Optional lazy-sync (RDL/WRC reservation) support: define OCP_SLAVE_MEM_LAZYSYNC_EN.
module ocp_slave_mem
    import ocp_slave_mem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              MCmd,
    input  logic [ADDR_WIDTH-1:0]   MAddr,
    input  logic [DATA_WIDTH-1:0]   MData,
    input  logic [DATA_WIDTH/8-1:0] MByteEn,
    output logic                    SCmdAccept,
    output logic [1:0]              SResp,
    output logic [DATA_WIDTH-1:0]   SData,
    input  logic                    MRespAccept
);

    localparam int unsigned OFF_W = clog2(DATA_WIDTH/8);
    localparam int unsigned IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    Ocp_cmd                cmd;
    logic [ADDR_WIDTH-1:0] widx;
    logic [IDX_W-1:0]      mem_addr;
    logic                  in_range;
    logic                  xfer;
    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rdata;
    Ocp_resp               resp_n;
    logic                  rd_n;

    slot_e                 slot;
    Ocp_resp               sresp;
    logic                  resp_rd;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign widx     = (MAddr - BASE_ADDR) >> OFF_W;
    assign in_range = widx < ADDR_WIDTH'(DEPTH);
    assign mem_addr = widx[IDX_W-1:0];
    assign cmd      = Ocp_cmd'(MCmd);

    assign SCmdAccept = reset && ((slot == SLOT_EMPTY) || MRespAccept);
    assign xfer       = (cmd != IDLE) && SCmdAccept;
    assign SResp      = sresp;
    assign SData      = resp_rd ? rdata : '0;

`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic             res_hit;
    logic             res_set;
    logic             res_clr;

    assign res_hit = res_valid && in_range && (res_idx == mem_addr);
`endif

    always_comb begin
        mem_en = 1'b0;
        mem_we = 1'b0;
        resp_n = NULL;
        rd_n   = 1'b0;
`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
        res_set = 1'b0;
        res_clr = 1'b0;
`endif
        if (xfer) begin
            case (cmd)
                WR, BCST, WRNP: begin
                    mem_en = in_range;
                    mem_we = in_range;
                    if (cmd == WRNP) resp_n = in_range ? DVA : ERR;
`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
                    res_clr = res_hit;
`endif
                end
                RD, RDEX, RDL: begin
                    mem_en = in_range;
                    rd_n   = in_range;
                    resp_n = in_range ? DVA : ERR;
`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
                    if (cmd == RDL) begin
                        res_set = in_range;
                        res_clr = !in_range;
                    end
`endif
                end
                WRC: begin
`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
                    res_clr = 1'b1;
                    if (!in_range) begin
                        resp_n = ERR;
                    end else if (res_hit) begin
                        mem_en = 1'b1;
                        mem_we = 1'b1;
                        resp_n = DVA;
                    end else begin
                        resp_n = FAIL;
                    end
`else
                    resp_n = ERR;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot    <= SLOT_EMPTY;
            sresp   <= NULL;
            resp_rd <= 1'b0;
`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
            res_valid <= 1'b0;
            res_idx   <= '0;
`endif
        end else begin
            if (xfer && needs_resp(cmd)) begin
                slot    <= SLOT_FULL;
                sresp   <= resp_n;
                resp_rd <= rd_n;
            end else if ((slot == SLOT_FULL) && MRespAccept) begin
                slot    <= SLOT_EMPTY;
                sresp   <= NULL;
                resp_rd <= 1'b0;
            end
`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
            if (res_set) begin
                res_valid <= 1'b1;
                res_idx   <= mem_addr;
            end else if (res_clr) begin
                res_valid <= 1'b0;
            end
`endif
        end
    end

    ocp_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .be    (MByteEn),
        .addr  (mem_addr),
        .wdata (MData),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Randomised self-checking bench for ocp_slave_mem against a word-array reference model.
module tb_ocp_slave_mem;
    import ocp_slave_mem_pkg::*;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MCmd;
    logic [31:0] MAddr;
    logic [31:0] MData;
    logic [3:0]  MByteEn;
    logic        SCmdAccept;
    logic [1:0]  SResp;
    logic [31:0] SData;
    logic        MRespAccept;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mdl_mem [DEPTH];
    bit          mdl_rv = 0;
    int unsigned mdl_ri = 0;

    always #5 clk = ~clk;

    ocp_slave_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MCmd        (MCmd),
        .MAddr       (MAddr),
        .MData       (MData),
        .MByteEn     (MByteEn),
        .SCmdAccept  (SCmdAccept),
        .SResp       (SResp),
        .SData       (SData),
        .MRespAccept (MRespAccept)
    );

    task automatic model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [1:0] er, output logic [31:0] ed);
        int unsigned w;
        bit inr;
        w   = a >> 2;
        inr = (w < DEPTH);
        er  = NULL;
        ed  = '0;
        case (c)
            WR, BCST, WRNP: begin
                if (inr) begin
                    for (int b = 0; b < 4; b++) if (be[b]) mdl_mem[w][8*b +: 8] = d[8*b +: 8];
                    if (mdl_rv && mdl_ri == w) mdl_rv = 0;
                end
                if (c == WRNP) er = inr ? DVA : ERR;
            end
            RD, RDEX, RDL: begin
                if (inr) begin
                    er = DVA;
                    ed = mdl_mem[w];
                end else begin
                    er = ERR;
                end
`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
                if (c == RDL) begin
                    mdl_rv = inr;
                    mdl_ri = w;
                end
`endif
            end
            WRC: begin
`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
                if (!inr) er = ERR;
                else if (mdl_rv && mdl_ri == w) begin
                    for (int b = 0; b < 4; b++) if (be[b]) mdl_mem[w][8*b +: 8] = d[8*b +: 8];
                    er = DVA;
                end else er = FAIL;
                mdl_rv = 0;
`else
                er = ERR;
`endif
            end
            default: ;
        endcase
    endtask

    // Drives one command, waits for acceptance, samples the response a cycle later.
    task automatic txn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [1:0] gr, output logic [31:0] gd,
                       output logic [1:0] er, output logic [31:0] ed);
        int n;
        @(negedge clk);
        MCmd = c; MAddr = a; MData = d; MByteEn = be; MRespAccept = 1'b1;
        #1;
        n = 0;
        while (!SCmdAccept && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!SCmdAccept) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout got=0 want=1");
        end
        @(posedge clk); #1;
        MCmd = IDLE;
        @(negedge clk);
        gr = SResp;
        gd = SData;
        model(c, a, d, be, er, ed);
    endtask

    task automatic test_reset();
        reset = 1'b1; MCmd = IDLE; MAddr = '0; MData = '0; MByteEn = '0; MRespAccept = 1'b1;
        #1 reset = 1'b0;
        #20;
        vectors++; if (SResp !== NULL) begin miscompares++; $display("FAIL reset_sresp got=%0d want=0", SResp); end
        vectors++; if (SCmdAccept !== 1'b0) begin miscompares++; $display("FAIL reset_accept got=%b want=0", SCmdAccept); end
        vectors++; if (SData !== 32'h0) begin miscompares++; $display("FAIL reset_sdata got=%h want=0", SData); end
        @(negedge clk); reset = 1'b1; #1;
        vectors++; if (SCmdAccept !== 1'b1) begin miscompares++; $display("FAIL release_accept got=%b want=1", SCmdAccept); end
    endtask

    task automatic test_fill();
        logic [1:0] gr, er; logic [31:0] gd, ed;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            txn(WR, i * 4, $urandom, 4'hF, gr, gd, er, ed);
            vectors++; if (gr !== er) begin miscompares++; $display("FAIL fill_resp i=%0d got=%0d want=%0d", i, gr, er); end
        end
    endtask

    task automatic test_wrnp_rd();
        logic [1:0] gr, er; logic [31:0] gd, ed;
        txn(WRNP, 32'h10, 32'hDEADBEEF, 4'hF, gr, gd, er, ed);
        vectors++; if (gr !== DVA || gd !== 32'h0) begin miscompares++; $display("FAIL wrnp_resp got=%0d/%h want=1/0", gr, gd); end
        txn(RD, 32'h10, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gr !== DVA || gd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_after_wrnp got=%0d/%h want=1/deadbeef", gr, gd); end
    endtask

    task automatic test_byteen();
        logic [1:0] gr, er; logic [31:0] gd, ed;
        txn(WR, 32'h20, 32'hFFFFFFFF, 4'hF, gr, gd, er, ed);
        txn(WR, 32'h20, 32'h11223344, 4'b0101, gr, gd, er, ed);
        vectors++; if (gr !== NULL) begin miscompares++; $display("FAIL posted_wr_resp got=%0d want=0", gr); end
        txn(RD, 32'h22, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gr !== DVA || gd !== 32'hFF22FF44) begin miscompares++; $display("FAIL byteen_rd got=%0d/%h want=1/ff22ff44", gr, gd); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] gr, er; logic [31:0] gd, ed;
        txn(RD, 32'h400, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gr !== ERR || gd !== 32'h0) begin miscompares++; $display("FAIL oor_rd got=%0d/%h want=3/0", gr, gd); end
        txn(WR, 32'h400, 32'hA5A5A5A5, 4'hF, gr, gd, er, ed);
        vectors++; if (gr !== NULL) begin miscompares++; $display("FAIL oor_wr_resp got=%0d want=0", gr); end
        txn(RD, 32'h0, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gr !== er || gd !== ed) begin miscompares++; $display("FAIL oor_no_alias got=%0d/%h want=%0d/%h", gr, gd, er, ed); end
        txn(WRNP, 32'hFFFFFFFC, 32'h1, 4'hF, gr, gd, er, ed);
        vectors++; if (gr !== ERR || gd !== 32'h0) begin miscompares++; $display("FAIL oor_wrnp got=%0d/%h want=3/0", gr, gd); end
    endtask

    task automatic test_backpressure();
        logic [1:0] e1r, e2r; logic [31:0] e1d, e2d;
        @(negedge clk);
        MCmd = RD; MAddr = 32'h30; MRespAccept = 1'b1;
        model(RD, 32'h30, 32'h0, 4'h0, e1r, e1d);
        @(posedge clk); #1;
        MCmd = RD; MAddr = 32'h34; MRespAccept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (SCmdAccept !== 1'b0) begin miscompares++; $display("FAIL bp_accept cyc=%0d got=%b want=0", i, SCmdAccept); end
            vectors++; if (SResp !== e1r || SData !== e1d) begin miscompares++; $display("FAIL bp_hold cyc=%0d got=%0d/%h want=%0d/%h", i, SResp, SData, e1r, e1d); end
        end
        MRespAccept = 1'b1; #1;
        vectors++; if (SCmdAccept !== 1'b1) begin miscompares++; $display("FAIL bp_release_accept got=%b want=1", SCmdAccept); end
        model(RD, 32'h34, 32'h0, 4'h0, e2r, e2d);
        @(posedge clk); #1;
        MCmd = IDLE;
        @(negedge clk);
        vectors++; if (SResp !== e2r || SData !== e2d) begin miscompares++; $display("FAIL bp_next_resp got=%0d/%h want=%0d/%h", SResp, SData, e2r, e2d); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e1r, e2r, e3r, e4r; logic [31:0] e1d, e2d, e3d, e4d, wd;
        wd = $urandom;
        @(negedge clk);
        MCmd = RD; MAddr = 32'h40; MRespAccept = 1'b1;
        model(RD, 32'h40, 32'h0, 4'h0, e1r, e1d);
        @(posedge clk); #1;
        MCmd = RD; MAddr = 32'h44;
        model(RD, 32'h44, 32'h0, 4'h0, e2r, e2d);
        @(negedge clk);
        vectors++; if (SCmdAccept !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got=%b want=1", SCmdAccept); end
        vectors++; if (SResp !== e1r || SData !== e1d) begin miscompares++; $display("FAIL b2b_r1 got=%0d/%h want=%0d/%h", SResp, SData, e1r, e1d); end
        @(posedge clk); #1;
        MCmd = WRNP; MAddr = 32'h44; MData = wd; MByteEn = 4'hF;
        model(WRNP, 32'h44, wd, 4'hF, e3r, e3d);
        @(negedge clk);
        vectors++; if (SResp !== e2r || SData !== e2d) begin miscompares++; $display("FAIL b2b_r2 got=%0d/%h want=%0d/%h", SResp, SData, e2r, e2d); end
        @(posedge clk); #1;
        MCmd = RD; MAddr = 32'h44;
        model(RD, 32'h44, 32'h0, 4'h0, e4r, e4d);
        @(negedge clk);
        vectors++; if (SResp !== e3r || SData !== e3d) begin miscompares++; $display("FAIL b2b_wrnp got=%0d/%h want=%0d/%h", SResp, SData, e3r, e3d); end
        @(posedge clk); #1;
        MCmd = IDLE;
        @(negedge clk);
        vectors++; if (SResp !== e4r || SData !== wd) begin miscompares++; $display("FAIL b2b_write_first got=%0d/%h want=%0d/%h", SResp, SData, e4r, wd); end
        @(negedge clk);
        vectors++; if (SResp !== NULL) begin miscompares++; $display("FAIL b2b_drain got=%0d want=0", SResp); end
    endtask

    task automatic test_lazysync();
        logic [1:0] gr, er; logic [31:0] gd, ed;
`ifdef OCP_SLAVE_MEM_LAZYSYNC_EN
        txn(RDL, 32'h8, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gr !== DVA || gd !== ed) begin miscompares++; $display("FAIL rdl got=%0d/%h want=1/%h", gr, gd, ed); end
        txn(WRC, 32'h8, 32'hCAFEF00D, 4'hF, gr, gd, er, ed);
        vectors++; if (gr !== DVA || gd !== 32'h0) begin miscompares++; $display("FAIL wrc_ok got=%0d/%h want=1/0", gr, gd); end
        txn(RD, 32'h8, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL wrc_written got=%h want=cafef00d", gd); end
        txn(RDL, 32'h8, 32'h0, 4'h0, gr, gd, er, ed);
        txn(WR, 32'h8, 32'h12345678, 4'hF, gr, gd, er, ed);
        txn(WRC, 32'h8, 32'h0BADBAD0, 4'hF, gr, gd, er, ed);
        vectors++; if (gr !== FAIL || gd !== 32'h0) begin miscompares++; $display("FAIL wrc_lost got=%0d/%h want=2/0", gr, gd); end
        txn(RD, 32'h8, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gd !== 32'h12345678) begin miscompares++; $display("FAIL wrc_kept_wr got=%h want=12345678", gd); end
`else
        txn(RDL, 32'h8, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gr !== DVA || gd !== ed) begin miscompares++; $display("FAIL rdl_as_rd got=%0d/%h want=1/%h", gr, gd, ed); end
        txn(WRC, 32'h8, 32'hCAFEF00D, 4'hF, gr, gd, er, ed);
        vectors++; if (gr !== ERR || gd !== 32'h0) begin miscompares++; $display("FAIL wrc_err got=%0d/%h want=3/0", gr, gd); end
        txn(RD, 32'h8, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gd !== ed) begin miscompares++; $display("FAIL wrc_nowrite got=%h want=%h", gd, ed); end
`endif
    endtask

    task automatic test_random();
        logic [1:0] gr, er; logic [31:0] gd, ed, a;
        logic [2:0] c;
        int unsigned r;
        for (int i = 0; i < 300; i++) begin
            c = 3'($urandom_range(1, 7));
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom | 32'h8000_0000;
            else if (r == 1) a = 4 * DEPTH + $urandom_range(0, 255);
            else if (r < 6)  a = $urandom_range(8, 15);
            else             a = $urandom_range(0, 4 * DEPTH - 1);
            txn(c, a, $urandom, 4'($urandom), gr, gd, er, ed);
            vectors++;
            if (gr !== er || gd !== ed) begin
                miscompares++;
                $display("FAIL random i=%0d cmd=%0d addr=%h got=%0d/%h want=%0d/%h", i, c, a, gr, gd, er, ed);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] gr, er; logic [31:0] gd, ed;
        @(negedge clk);
        MCmd = RD; MAddr = 32'h10; MRespAccept = 1'b1;
        @(posedge clk); #1;
        MCmd = IDLE;
        @(negedge clk);
        vectors++; if (SResp !== DVA) begin miscompares++; $display("FAIL mid_pending got=%0d want=1", SResp); end
        #2 reset = 1'b0;
        mdl_rv = 0;
        #1;
        vectors++; if (SResp !== NULL || SCmdAccept !== 1'b0 || SData !== 32'h0) begin
            miscompares++; $display("FAIL mid_async got=%0d/%b/%h want=0/0/0", SResp, SCmdAccept, SData);
        end
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        txn(RD, 32'h10, 32'h0, 4'h0, gr, gd, er, ed);
        vectors++; if (gr !== DVA || gd !== ed) begin miscompares++; $display("FAIL mid_first_rd got=%0d/%h want=1/%h", gr, gd, ed); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrnp_rd();
        test_byteen();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_lazysync();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ocp_slave_mem.md
Name: ocp_slave_mem

Overview:
- OCP responder (slave) terminating the on-chip bus in a word-addressed local memory. It accepts master commands of type Bus::Ocp_cmd and returns Bus::Ocp_resp responses.
- Serves as the standard endpoint for register banks and scratch RAMs behind the bus fabric.
- Sits opposite the existing OCP initiators and is the response side of the same protocol.

Parameters:
- ADDR_WIDTH, 32: MAddr width, byte address.
- DATA_WIDTH, 32: MData/SData width, multiple of 8.
- DEPTH, 256: number of words in local memory.
- BASE_ADDR, 0: byte address of word 0.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- MCmd  in  3  Bus::Ocp_cmd; IDLE = no request.
- MAddr  in  ADDR_WIDTH  byte address.
- MData  in  DATA_WIDTH  write data.
- MByteEn  in  DATA_WIDTH/8  byte enables for writes.
- SCmdAccept  out  1  command accepted this cycle.
- SResp  out  2  Bus::Ocp_resp; NULL = no response.
- SData  out  DATA_WIDTH  read data, valid with SResp=DVA on reads.
- MRespAccept  in  1  master consumes the response this cycle.

Behaviour:
- Reset: SCmdAccept=0, SResp=NULL, SData=0; response slot empty; reservation cleared. Memory contents are not reset.
- Word index = (MAddr - BASE_ADDR) >> Bus::clog2(DATA_WIDTH/8). Low address bits are ignored. Subtraction is unsigned at ADDR_WIDTH, so an address below BASE wraps high and decodes out of range.
- In range = index < DEPTH.
- SCmdAccept = reset deasserted && (slot empty || (SResp!=NULL && MRespAccept)). It is combinational on the slot state and MRespAccept.
- A command transfers in a cycle with MCmd!=IDLE && SCmdAccept.
- Slot FSM:
  - EMPTY -> FULL on accepting any response-generating command.
  - FULL -> EMPTY on MRespAccept with no new command.
  - FULL -> FULL on MRespAccept together with a new response-generating command (back-to-back, one per cycle).
- Latency: response is registered and visible on SResp/SData the cycle after acceptance. It is held stable until MRespAccept.
- Per command:
  - WR, BCST: posted. Bytes written per MByteEn if in range; silently dropped if out of range. No response, so the slot is unchanged.
  - WRNP: write as WR. Response DVA if in range, ERR if out of range (no write).
  - RD, RDEX: SData = mem[index], DVA. Out of range gives ERR with SData=0.
  - RDL, WRC: see Optional Feature.
- SData is 0 for every non-read response.
- Read of a word written by the immediately preceding accepted command returns the new data (write-first).
- Reset mid-transfer: pending response discarded, SResp=NULL immediately (asynchronous).

Optional Feature:
- Macro OCP_SLAVE_MEM_LAZYSYNC_EN.
- With the macro:
  - RDL performs RD and sets reservation {valid, index}.
  - WRC with valid reservation and matching index writes and returns DVA, then clears the reservation.
  - Otherwise WRC returns FAIL with no write; the reservation is cleared.
  - Any WR/WRNP/BCST to the reserved index clears the reservation.
  - RDL/WRC out of range return ERR; reservation cleared.
- Without the macro: RDL behaves as RD; WRC returns ERR with no write; no reservation logic is synthesised.

Decomposition:
- Bus package gains:
  - typedef struct Ocp_req {Ocp_cmd cmd; addr; data; byteen}, width-parameterised via package parameters or left as separate ports;
  - helper function is_write(Ocp_cmd) and is_read(Ocp_cmd);
  - function needs_resp(Ocp_cmd), true for all except IDLE, WR, BCST.
- Index math uses the existing Bus::clog2.
- One sub-module: ocp_slave_mem_array, a byte-enabled single-port memory with registered read, instantiated once.

Test Plan:
- WRNP addr 0x10 data 0xDEADBEEF byteen 4'hF, then RD 0x10 -> SResp DVA, then DVA with SData=0xDEADBEEF, each one cycle after accept.
- WR 0x20 data 0x11223344 byteen 4'b0101 over 0xFFFFFFFF, then RD -> SData=0xFF22FF44; no response for the WR.
- RD to byte address 4*DEPTH=0x400 -> ERR with SData=0; WR to 0x400 -> no response, memory unchanged.
- Hold MRespAccept=0 for 3 cycles with RD pending while MCmd=RD is presented -> SCmdAccept=0, SResp stable. Then MRespAccept=1 -> new command accepted the same cycle, next response the following cycle.
- With OCP_SLAVE_MEM_LAZYSYNC_EN:
  - RDL 0x8, then WRC 0x8 -> DVA, written.
  - Repeat with an intervening WR 0x8 -> WRC gives FAIL, data from the WR retained.
  - Without the macro, WRC -> ERR.
- Assert reset while SResp=DVA pending -> SResp=NULL asynchronously, SCmdAccept=0. After release, the slot is empty and the first RD completes normally.
